div512_r2_seq: RTL and testbench

DIV512_R2_SEQ -- requirements
Module: div512_r2_seq

---
 rtl/div512_pkg.sv | 21 ++
 rtl/div_sub_stage.sv | 23 ++
 rtl/div512_r2_seq.sv | 150 +++++++++++++++
 tb/tb_div512_r2_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/div512_pkg.sv
// ---------------------------------------------------------------------------
// div512_pkg
// Shared definitions for the 512/256 radix-2 sequential divider.
//   NW_DEF  : default dividend width
//   DW_DEF  : default divisor / quotient / remainder width (NW = 2*DW)
//   ITER    : number of radix-2 iterations in one division
//   state_t : controller state encoding
// ---------------------------------------------------------------------------
package div512_pkg;

    localparam int NW_DEF = 512;
    localparam int DW_DEF = 256;
    localparam int ITER   = DW_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_sub_stage.sv
// ---------------------------------------------------------------------------
// div_sub_stage
// Trial subtractor for one restoring radix-2 step.
//   pr     : in  DW+1 shifted partial remainder
//   d      : in  DW   divisor
//   diff   : out DW   pr - d (only meaningful when borrow is low)
//   borrow : out 1    high when pr < d, i.e. the trial result is negative
// When there is no borrow, the difference is below d and therefore fits in
// DW bits, so the top bit of the subtraction is never needed.
// ---------------------------------------------------------------------------
module div_sub_stage #(
    parameter int DW = 256
) (
    input  logic [DW:0]   pr,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] diff,
    output logic          borrow
);

    assign borrow = (pr < {1'b0, d});
    assign diff   = pr[DW-1:0] - d;

endmodule

// File: rtl/div512_r2_seq.sv
// ---------------------------------------------------------------------------
// div512_r2_seq
// Sequential restoring radix-2 unsigned divider, NW-bit dividend by DW-bit
// divisor, one quotient bit per enabled clock.
//   clk   : in  1   clock, rising edge
//   rst_n : in  1   asynchronous active-low reset
//   en    : in  1   clock enable, low freezes everything
//   start : in  1   request, sampled only in IDLE
//   N     : in  NW  dividend, captured on acceptance
//   D     : in  DW  divisor, captured on acceptance
//   Q     : out DW  quotient (all ones on overflow)
//   R     : out DW  remainder (zero on overflow)
//   busy  : out 1   high while iterating
//   done  : out 1   one-cycle result-valid marker
//   ovf   : out 1   divide by zero or quotient wider than DW bits
// ---------------------------------------------------------------------------
module div512_r2_seq
    import div512_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          start,
    input  logic [NW-1:0] N,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q,
    output logic [DW-1:0] R,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rem;
    logic [DW-1:0] d_reg;
    // Holds the not-yet-consumed dividend bits at the top and the quotient
    // bits produced so far at the bottom; both shift left together.
    logic [DW-1:0] nlo;

    logic [DW:0]   shifted;
    logic [DW-1:0] diff;
    logic          borrow;
    logic          qbit;
    logic [DW-1:0] rem_keep;
    logic          ovf_cond;

    assign ovf_cond = (D == '0) || (N[NW-1:DW] >= D);

    assign shifted  = {rem, nlo[DW-1]};
    assign qbit     = ~borrow;
    assign rem_keep = borrow ? shifted[DW-1:0] : diff;

    div_sub_stage #(
        .DW (DW)
    ) u_sub (
        .pr     (shifted),
        .d      (d_reg),
        .diff   (diff),
        .borrow (borrow)
    );

    // State register, frozen while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (en) begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ovf_cond ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            rem   <= '0;
            d_reg <= '0;
            nlo   <= '0;
            Q     <= '0;
            R     <= '0;
            ovf   <= 1'b0;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        d_reg <= D;
                        nlo   <= N[DW-1:0];
                        cnt   <= '0;
                        if (ovf_cond) begin
                            rem <= '0;
                            Q   <= '1;
                            R   <= '0;
                            ovf <= 1'b1;
                        end else begin
                            rem <= N[NW-1:DW];
                            ovf <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    rem <= rem_keep;
                    nlo <= {nlo[DW-2:0], qbit};
                    if (cnt == LAST) begin
                        cnt <= '0;
                        Q   <= {nlo[DW-2:0], qbit};
                        R   <= rem_keep;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div512_r2_seq.sv
// ---------------------------------------------------------------------------
// tb_div512_r2_seq
// Self-checking bench for div512_r2_seq: a table of directed divisions with
// hand-computed results, followed by hand-written sequences for clock-enable
// stalls, start requests while busy or done, and reset during an operation.
// Latency is counted in enabled edges, starting with the edge that accepts
// start: a normal division finishes after ITER+1 such edges, an overflow
// after one.
// ---------------------------------------------------------------------------
module tb_div512_r2_seq;
    import div512_pkg::*;

    localparam int NW = NW_DEF;
    localparam int DW = DW_DEF;
    localparam int LAT_NORMAL = ITER + 1;
    localparam int LAT_OVF = 1;
    localparam int NUM_VEC = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          start;
    logic [NW-1:0] n;
    logic [DW-1:0] d;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          busy;
    logic          done;
    logic          ovf;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [NW-1:0] n;
        logic [DW-1:0] d;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          ovf;
    } vec_t;

    vec_t vecs [NUM_VEC];

    always #5 clk = ~clk;

    div512_r2_seq #(
        .NW (NW),
        .DW (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .start (start),
        .N     (n),
        .D     (d),
        .Q     (q),
        .R     (r),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    // Compare one value and keep the tallies.
    task automatic checkOutput(input string name, input logic [NW-1:0] act,
                               input logic [NW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Launch one division and wait (bounded) for done, sampling on negedges.
    task automatic applyStimulus(input logic [NW-1:0] nv, input logic [DW-1:0] dv,
                                 output int lat, output bit busy_gap,
                                 output bit busy_seen);
        @(negedge clk);
        n     = nv;
        d     = dv;
        en    = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        lat       = 1;
        busy_gap  = 1'b0;
        busy_seen = 1'b0;
        while (!done && lat < 1000) begin
            if (busy) busy_seen = 1'b1;
            else      busy_gap  = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int  lat;
        bit  gap;
        bit  seen;
        bit  done_seen;
        logic [DW-1:0] maxd;

        rst_n = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        n     = '0;
        d     = '0;
        maxd  = '1;

        #12;
        checkOutput("reset Q", NW'(q), '0);
        checkOutput("reset R", NW'(r), '0);
        checkOutput("reset busy/done/ovf", NW'({busy, done, ovf}), '0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{n: 512'd100, d: 256'd7, q: 256'd14, r: 256'd2, ovf: 1'b0};
        vecs[1] = '{n: 512'd1 << 300, d: 256'd1 << 100, q: 256'd1 << 200, r: '0, ovf: 1'b0};
        vecs[2] = '{n: (512'd3 << 256) - 512'd1, d: 256'd3, q: '1, r: 256'd2, ovf: 1'b0};
        vecs[3] = '{n: 512'd3 << 256, d: 256'd3, q: '1, r: '0, ovf: 1'b1};
        vecs[4] = '{n: 512'd12345, d: '0, q: '1, r: '0, ovf: 1'b1};
        vecs[5] = '{n: 512'd12345678, d: 256'd1000, q: 256'd12345, r: 256'd678, ovf: 1'b0};
        vecs[6] = '{n: '0, d: 256'd5, q: '0, r: '0, ovf: 1'b0};
        vecs[7] = '{n: (512'd1 << 256) - 512'd1, d: 256'd1, q: '1, r: '0, ovf: 1'b0};
        vecs[8] = '{n: {maxd - 256'd1, maxd}, d: maxd, q: '1, r: maxd - 256'd1, ovf: 1'b0};
        vecs[9] = '{n: '1, d: maxd, q: '1, r: '0, ovf: 1'b1};

        for (int i = 0; i < NUM_VEC; i++) begin
            applyStimulus(vecs[i].n, vecs[i].d, lat, gap, seen);
            checkOutput($sformatf("v%0d Q", i), NW'(q), NW'(vecs[i].q));
            checkOutput($sformatf("v%0d R", i), NW'(r), NW'(vecs[i].r));
            checkOutput($sformatf("v%0d ovf", i), NW'(ovf), NW'(vecs[i].ovf));
            checkOutput($sformatf("v%0d latency", i), NW'(lat),
                        NW'(vecs[i].ovf ? LAT_OVF : LAT_NORMAL));
            checkOutput($sformatf("v%0d busy seen/gap", i), NW'({seen, gap}),
                        NW'(vecs[i].ovf ? 2'b00 : 2'b10));
            @(negedge clk);
            checkOutput($sformatf("v%0d done one cycle", i), NW'(done), '0);
            checkOutput($sformatf("v%0d Q held", i), NW'(q), NW'(vecs[i].q));
        end

        // Clock-enable stall mid-run plus a start request while busy.
        @(negedge clk);
        n     = 512'd100;
        d     = 256'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        repeat (49) begin
            @(negedge clk);
            lat++;
        end
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("stall busy held", NW'({busy, done}), NW'(2'b10));
        en    = 1'b1;
        n     = 512'd999;
        d     = 256'd3;
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("stall latency", NW'(lat), NW'(LAT_NORMAL + 10));
        checkOutput("stall Q", NW'(q), NW'(256'd14));
        checkOutput("stall R", NW'(r), NW'(256'd2));
        checkOutput("stall ovf", NW'(ovf), '0);

        // done must hold while en is low, then drop; the busy-time start is gone.
        en = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("done frozen by en", NW'(done), NW'(1'b1));
        en = 1'b1;
        @(negedge clk);
        checkOutput("after stall busy/done", NW'({busy, done}), '0);
        repeat (3) @(negedge clk);
        checkOutput("busy start ignored", NW'(busy), '0);

        // A start seen during DONE must not launch another division.
        applyStimulus(512'd12345678, 256'd1000, lat, gap, seen);
        n     = 512'd100;
        d     = 256'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done start ignored busy/done", NW'({busy, done}), '0);
        checkOutput("done start ignored Q", NW'(q), NW'(256'd12345));

        // Reset in the middle of an operation.
        @(negedge clk);
        n     = 512'd100;
        d     = 256'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("pre-reset busy", NW'(busy), NW'(1'b1));
        rst_n = 1'b0;
        #1;
        checkOutput("mid-run reset Q", NW'(q), '0);
        checkOutput("mid-run reset R", NW'(r), '0);
        checkOutput("mid-run reset busy/done/ovf", NW'({busy, done, ovf}), '0);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (done || busy) done_seen = 1'b1;
        end
        checkOutput("no activity after reset", NW'(done_seen), '0);

        applyStimulus(512'd50, 256'd5, lat, gap, seen);
        checkOutput("post-reset Q", NW'(q), NW'(256'd10));
        checkOutput("post-reset R", NW'(r), '0);
        checkOutput("post-reset ovf", NW'(ovf), '0);
        checkOutput("post-reset latency", NW'(lat), NW'(LAT_NORMAL));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
